fifo_write_ctrl: RTL and testbench

//  Write-domain controller of the async FIFO, paired with the read-side pointer/empty logic.
//  - Owns the binary and Gray write pointers and drives the dual-port RAM write address/enable.
//  - Syncs the read Gray pointer into wclk (2 FF) and derives registered full, almost_full,
//    a conservative fill level and a sticky overflow flag.

---
 rtl/fifo_write_ctrl_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/fifo_write_ctrl.sv | 89 ++++++++
 tb/tb_fifo_write_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_ctrl_pkg.sv
// Shared defaults and Gray helpers for the async FIFO.
// Used by both the write and read pointer controllers.
package fifo_write_ctrl_pkg;

  localparam int DEF_A_SIZE   = 4;
  localparam int DEF_AF_LEVEL = 12;

  // Functions work on 32-bit values.
  // Callers zero-extend their input and truncate the result.
  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with async active-low reset.
// Ports: clk_i, rst_ni, d_i (async in), q_o (synced out).
module sync_2ff #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/fifo_write_ctrl.sv
// Async FIFO write-side controller: pointers, full/almost_full,
// level, sticky overflow. Ports: wclk, wrstn, wen, rptr, ovf_clr
// in; wmem_en, waddr, wptr, full, almost_full, wlevel, overflow out.
module fifo_write_ctrl
  import fifo_write_ctrl_pkg::*;
#(
  parameter int A_SIZE   = DEF_A_SIZE,
  parameter int AF_LEVEL = DEF_AF_LEVEL
) (
  input  logic              wclk,
  input  logic              wrstn,
  input  logic              wen,
  input  logic [A_SIZE:0]   rptr,
  input  logic              ovf_clr,
  output logic              wmem_en,
  output logic [A_SIZE-1:0] waddr,
  output logic [A_SIZE:0]   wptr,
  output logic              full,
  output logic              almost_full,
  output logic [A_SIZE:0]   wlevel,
  output logic              overflow
);

  localparam int PW = A_SIZE + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] lvl_q, lvl_d;
  logic [PW-1:0] wrptr2;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] full_cmp;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          acc;

  sync_2ff #(
    .W(PW)
  ) u_rsync (
    .clk_i (wclk),
    .rst_ni(wrstn),
    .d_i   (rptr),
    .q_o   (wrptr2)
  );

  assign acc    = wen & ~full_q;
  assign wbin_d = wbin_q + PW'(acc);
  assign wptr_d = PW'(bin2gray(32'(wbin_d)));
  assign rbin_s = PW'(gray2bin(32'(wrptr2)));

  // Full when the next write pointer sits one lap ahead of the
  // synced read pointer: Gray form has the top two bits inverted.
  assign full_cmp = {~wrptr2[A_SIZE:A_SIZE-1],
                     wrptr2[A_SIZE-2:0]};
  assign full_d   = (wptr_d == full_cmp);

  assign lvl_d = wbin_d - rbin_s;
  assign af_d  = 32'(lvl_d) >= 32'(AF_LEVEL);

  // A fresh overflow beats a simultaneous clear.
  assign ovf_d = (wen & full_q) | (ovf_q & ~ovf_clr);

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      wbin_q <= '0;
      wptr_q <= '0;
      lvl_q  <= '0;
      full_q <= 1'b0;
      af_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wbin_q <= wbin_d;
      wptr_q <= wptr_d;
      lvl_q  <= lvl_d;
      full_q <= full_d;
      af_q   <= af_d;
      ovf_q  <= ovf_d;
    end
  end

  assign wmem_en     = acc;
  assign waddr       = wbin_q[A_SIZE-1:0];
  assign wptr        = wptr_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign wlevel      = lvl_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Randomized scoreboard bench for fifo_write_ctrl.
// Model tracks write/read counts as plain integers.
module tb_fifo_write_ctrl;

  logic       wclk = 1'b0;
  logic       wrstn = 1'b0;
  logic       wen = 1'b0;
  logic [4:0] rptr = '0;
  logic       ovf_clr = 1'b0;
  logic       wmem_en;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       full;
  logic       almost_full;
  logic [4:0] wlevel;
  logic       overflow;

  fifo_write_ctrl #(
    .A_SIZE  (4),
    .AF_LEVEL(12)
  ) dut (
    .wclk       (wclk),
    .wrstn      (wrstn),
    .wen        (wen),
    .rptr       (rptr),
    .ovf_clr    (ovf_clr),
    .wmem_en    (wmem_en),
    .waddr      (waddr),
    .wptr       (wptr),
    .full       (full),
    .almost_full(almost_full),
    .wlevel     (wlevel),
    .overflow   (overflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic       men;
    logic [3:0] wa;
    logic [4:0] wp;
    logic       f;
    logic       af;
    logic [4:0] lv;
    logic       ov;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // model state
  int   m_wr;
  int   m_rd;
  bit   m_full;
  bit   m_ovf;
  int   hist[$];

  function automatic logic [4:0] g5(input int v);
    logic [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input int act,
                     input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, want %0d",
               nm, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    m_wr   = 0;
    m_rd   = 0;
    m_full = 0;
    m_ovf  = 0;
    hist.delete();
    hist.push_back(0);
    hist.push_back(0);
  endtask

  task automatic step(input bit wv, input int rd,
                      input bit clr);
    exp_t e;
    int   vis;
    int   occ;
    @(negedge wclk);
    wen     = wv;
    ovf_clr = clr;
    m_rd    = rd;
    rptr    = g5(rd);
    hist.push_back(rd);
    e.men = wv && !m_full;
    e.wa  = 4'(m_wr % 16);
    if (e.men) m_wr++;
    // register outputs see the read value sampled two edges back
    vis    = hist[hist.size()-3];
    occ    = m_wr - vis;
    m_ovf  = (wv && m_full) || (m_ovf && !clr);
    m_full = (occ >= 16);
    e.f  = m_full;
    e.af = (occ >= 12);
    e.lv = 5'(occ);
    e.wp = g5(m_wr);
    e.ov = m_ovf;
    q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wmem_en"}, int'(wmem_en), 0);
    chk({tag, "_waddr"}, int'(waddr), 0);
    chk({tag, "_wptr"}, int'(wptr), 0);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_af"}, int'(almost_full), 0);
    chk({tag, "_wlevel"}, int'(wlevel), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
  endtask

  task automatic do_reset();
    @(posedge wclk);
    #3;
    wrstn   = 1'b0;
    wen     = 1'b0;
    ovf_clr = 1'b0;
    rptr    = '0;
    #1;
    chk_zero("rst_async");
    model_reset();
    @(negedge wclk);
    wrstn = 1'b1;
  endtask

  // monitor: comb sample before edge, registered after
  logic       s_men;
  logic [3:0] s_wa;
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      #2;
      s_men = wmem_en;
      s_wa  = waddr;
      @(posedge wclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wmem_en", int'(s_men), int'(e.men));
        chk("waddr", int'(s_wa), int'(e.wa));
        chk("wptr", int'(wptr), int'(e.wp));
        chk("full", int'(full), int'(e.f));
        chk("almost_full", int'(almost_full), int'(e.af));
        chk("wlevel", int'(wlevel), int'(e.lv));
        chk("overflow", int'(overflow), int'(e.ov));
      end
    end
  end

  initial begin
    int rd;
    model_reset();
    #1;
    chk_zero("rst_init");
    @(negedge wclk);
    wrstn = 1'b1;

    // random writes, then reset mid-run
    for (int i = 0; i < 6; i++)
      step(1'($urandom), 0, 1'b0);
    do_reset();

    // fill from empty, crossing the almost_full threshold
    for (int i = 0; i < 16; i++) step(1'b1, 0, 1'b0);

    // writes while full, then clear handling
    for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    step(1'b1, 0, 1'b0);
    step(1'b1, 0, 1'b0);
    step(1'b1, 0, 1'b1);
    step(1'b0, 0, 1'b0);

    // read pointer advances to 4 while full
    for (int i = 0; i < 5; i++) step(1'b0, 4, 1'b0);
    do_reset();

    // streaming with reader trailing by 3
    for (int i = 0; i < 40; i++) begin
      rd = (m_wr > 3) ? m_wr - 3 : 0;
      step(1'b1, rd, 1'b0);
    end

    // random traffic
    rd = m_rd;
    for (int i = 0; i < 300; i++) begin
      rd += $urandom_range(0, 2);
      if (rd > m_wr) rd = m_wr;
      step(($urandom % 4) != 0, rd,
           ($urandom % 8) == 0);
    end

    step(1'b0, rd, 1'b0);
    step(1'b0, rd, 1'b0);
    @(posedge wclk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
